// File: rtl/solar_tracker_hyst_pkg.sv
// Shared types and default constants for the four-quadrant solar tracker.
package tracker_pkg;

  // Controller state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Move direction; the encoding doubles as the comparator-bank index
  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  localparam int DEF_LS_W    = 8;
  localparam int DEF_TH_ON   = 10;
  localparam int DEF_TH_OFF  = 2;
  localparam int DEF_MAX_RUN = 1000;
  localparam int DEF_SETTLE  = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/solar_tracker_hyst_if.sv
// Sensor samples in, motor enables and status out, bundled as one bus.
interface solar_tracker_hyst_if
  import tracker_pkg::*;
#(
  parameter int LS_W = DEF_LS_W
);
  logic            en;
  logic            clr_fault;
  logic [LS_W-1:0] lsn;
  logic [LS_W-1:0] lse;
  logic [LS_W-1:0] lss;
  logic [LS_W-1:0] lsw;
  logic            mn;
  logic            me;
  logic            ms;
  logic            mw;
  logic            busy;
  logic            fault;

  // Sensor/command side
  modport master (
    output en, clr_fault, lsn, lse, lss, lsw,
    input  mn, me, ms, mw, busy, fault
  );

  // Tracker controller side
  modport slave (
    input  en, clr_fault, lsn, lse, lss, lsw,
    output mn, me, ms, mw, busy, fault
  );
endinterface

// File: rtl/solar_tracker_hyst_pair_cmp.sv
// One-sided brightness compare: gt = a > b + th, done one bit wider so the
// sum never wraps.
module pair_cmp
  import tracker_pkg::*;
#(
  parameter int LS_W = DEF_LS_W
) (
  input  logic [LS_W-1:0] a,
  input  logic [LS_W-1:0] b,
  input  logic [LS_W-1:0] th,
  output logic            gt
);
  logic [LS_W:0] sum_ext;

  assign sum_ext = {1'b0, b} + {1'b0, th};
  assign gt      = {1'b0, a} > sum_ext;
endmodule

// File: rtl/solar_tracker_hyst.sv
// Four-quadrant solar tracker: starts a move toward the brighter side when a
// pair differs by more than TH_ON, stops once the difference falls to TH_OFF,
// then dwells SETTLE cycles. A move longer than MAX_RUN latches a fault.
module solar_tracker_hyst
  import tracker_pkg::*;
#(
  parameter int LS_W    = DEF_LS_W,
  parameter int TH_ON   = DEF_TH_ON,
  parameter int TH_OFF  = DEF_TH_OFF,
  parameter int MAX_RUN = DEF_MAX_RUN,
  parameter int SETTLE  = DEF_SETTLE
) (
  input logic                 clk,
  input logic                 rst,
  solar_tracker_hyst_if.slave bus
);
  localparam int RUN_W = cnt_w(MAX_RUN);
  localparam int SET_W = cnt_w(SETTLE);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(MAX_RUN - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [LS_W-1:0]  TH_ON_V     = LS_W'(TH_ON);
  localparam logic [LS_W-1:0]  TH_OFF_V    = LS_W'(TH_OFF);

  state_t           state_reg, state_next;
  dir_t             dir_reg, dir_next;
  logic [RUN_W-1:0] run_cnt_reg, run_cnt_next;
  logic [SET_W-1:0] settle_cnt_reg, settle_cnt_next;

  // Pair operands indexed by direction: [d] is "side d" vs "opposite side"
  logic [3:0][LS_W-1:0] side_s;
  logic [3:0][LS_W-1:0] opp_s;
  logic [3:0]           start_gt;
  logic [3:0]           hold_gt;
  logic                 start_any;
  dir_t                 start_dir;
  logic                 stop_now;

  assign side_s = {bus.lsw, bus.lss, bus.lse, bus.lsn};
  assign opp_s  = {bus.lse, bus.lsn, bus.lsw, bus.lss};

  // Start uses the wide threshold, stop the narrow one (hysteresis band)
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
      pair_cmp #(.LS_W(LS_W)) u_start (
        .a (side_s[gi]),
        .b (opp_s[gi]),
        .th(TH_ON_V),
        .gt(start_gt[gi])
      );
      pair_cmp #(.LS_W(LS_W)) u_stop (
        .a (side_s[gi]),
        .b (opp_s[gi]),
        .th(TH_OFF_V),
        .gt(hold_gt[gi])
      );
    end
  endgenerate

  // Active move keeps going only while its own side is still brighter than TH_OFF
  assign stop_now  = ~hold_gt[dir_reg];
  assign start_any = |start_gt;

  // Fixed priority N > E > S > W among simultaneous start requests
  always_comb begin
    start_dir = DIR_N;
    if (start_gt[0])      start_dir = DIR_N;
    else if (start_gt[1]) start_dir = DIR_E;
    else if (start_gt[2]) start_dir = DIR_S;
    else if (start_gt[3]) start_dir = DIR_W;
  end

  // State, direction and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dir_reg        <= DIR_N;
      run_cnt_reg    <= '0;
      settle_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      run_cnt_reg    <= run_cnt_next;
      settle_cnt_reg <= settle_cnt_next;
    end
  end

  // Next-state logic; in RUN a stop or disable outranks the watchdog
  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    run_cnt_next    = run_cnt_reg;
    settle_cnt_next = settle_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.en && start_any) begin
          state_next   = ST_RUN;
          dir_next     = start_dir;
          run_cnt_next = '0;
        end
      end
      ST_RUN: begin
        run_cnt_next = run_cnt_reg + RUN_W'(1);
        if (!bus.en || stop_now) begin
          settle_cnt_next = '0;
          state_next      = (SETTLE == 0) ? ST_IDLE : ST_SETTLE;
        end else if (run_cnt_reg == RUN_LAST) begin
          state_next = ST_FAULT;
        end
      end
      ST_SETTLE: begin
        settle_cnt_next = settle_cnt_reg + SET_W'(1);
        if (settle_cnt_reg == SETTLE_LAST) begin
          state_next = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (bus.clr_fault) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so at most one motor is on
  always_comb begin
    bus.mn    = 1'b0;
    bus.me    = 1'b0;
    bus.ms    = 1'b0;
    bus.mw    = 1'b0;
    bus.busy  = 1'b0;
    bus.fault = 1'b0;
    case (state_reg)
      ST_RUN: begin
        bus.busy = 1'b1;
        bus.mn   = (dir_reg == DIR_N);
        bus.me   = (dir_reg == DIR_E);
        bus.ms   = (dir_reg == DIR_S);
        bus.mw   = (dir_reg == DIR_W);
      end
      ST_SETTLE: bus.busy  = 1'b1;
      ST_FAULT:  bus.fault = 1'b1;
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_solar_tracker_hyst.sv
// Directed bench: each clock the stimulus pushes the expected outputs after
// that edge; a negedge monitor pops and compares.
module tb_solar_tracker_hyst;
  import tracker_pkg::*;

  // {mn, me, ms, mw, busy, fault}
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_N    = 6'b100010;
  localparam logic [5:0] E_E    = 6'b010010;
  localparam logic [5:0] E_S    = 6'b001010;
  localparam logic [5:0] E_W    = 6'b000110;
  localparam logic [5:0] E_SET  = 6'b000010;
  localparam logic [5:0] E_FLT  = 6'b000001;

  typedef struct {
    logic [5:0] exp;
    string      nm;
  } sb_t;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  sb_t  sb[$];

  solar_tracker_hyst_if #(.LS_W(8)) bus ();

  solar_tracker_hyst #(
    .LS_W   (8),
    .TH_ON  (10),
    .TH_OFF (2),
    .MAX_RUN(20),
    .SETTLE (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare outputs in the middle of each cycle
  always @(negedge clk) begin
    sb_t e;
    logic [5:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {bus.mn, bus.me, bus.ms, bus.mw, bus.busy, bus.fault};
      vec_cnt++;
      if (act !== e.exp) begin
        err_cnt++;
        $display("FAIL %s: got mn/me/ms/mw/busy/fault=%b expected %b", e.nm, act, e.exp);
      end else begin
        $display("ok   %s: %b", e.nm, act);
      end
    end
  end

  task automatic cyc(input logic [5:0] exp, input string nm);
    @(posedge clk);
    sb.push_back('{exp: exp, nm: nm});
    #1;
  endtask

  task automatic sense(input int n, input int e, input int s, input int w);
    bus.lsn = 8'(n);
    bus.lse = 8'(e);
    bus.lss = 8'(s);
    bus.lsw = 8'(w);
  endtask

  // First SETTLE cycle already pushed by caller; 15 more then IDLE
  task automatic settle_out(input string nm);
    for (int i = 0; i < 15; i++) cyc(E_SET, {nm, "_settle"});
    cyc(E_IDLE, {nm, "_idle"});
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.clr_fault = 1'b0;
    sense(0, 0, 0, 0);
    cyc(E_IDLE, "reset0");
    cyc(E_IDLE, "reset1");
    rst = 1'b0;

    // Basic start, hold inside hysteresis band, stop, settle dwell
    bus.en = 1'b1;
    sense(100, 50, 80, 50);
    cyc(E_N, "start_n");
    sense(100, 50, 95, 50);
    cyc(E_N, "hold_n0");
    cyc(E_N, "hold_n1");
    sense(100, 50, 98, 50);
    cyc(E_SET, "stop_n");
    settle_out("stop_n");

    // Difference of exactly TH_ON must not start
    sense(90, 50, 80, 50);
    cyc(E_IDLE, "hyst_eq");
    sense(91, 50, 80, 50);
    cyc(E_N, "hyst_start");
    sense(80, 50, 80, 50);
    cyc(E_SET, "hyst_stop");
    settle_out("hyst");

    // Priority N over E
    sense(200, 200, 0, 0);
    cyc(E_N, "prio_n");
    sense(100, 100, 100, 100);
    cyc(E_SET, "prio_stop");
    settle_out("prio");

    // No wrap of lsn+TH_ON
    sense(250, 100, 5, 100);
    cyc(E_N, "ovf_n");
    sense(100, 100, 100, 100);
    cyc(E_SET, "ovf_stop");
    settle_out("ovf");
    sense(255, 100, 250, 100);
    cyc(E_IDLE, "ovf_nomove0");
    cyc(E_IDLE, "ovf_nomove1");

    // Each remaining direction
    sense(100, 120, 100, 100);
    cyc(E_E, "dir_e");
    sense(100, 100, 100, 100);
    cyc(E_SET, "dir_e_stop");
    settle_out("dir_e");
    sense(100, 100, 120, 100);
    cyc(E_S, "dir_s");
    sense(100, 100, 100, 100);
    cyc(E_SET, "dir_s_stop");
    settle_out("dir_s");
    sense(100, 100, 100, 120);
    cyc(E_W, "dir_w");
    sense(100, 100, 100, 100);
    cyc(E_SET, "dir_w_stop");
    settle_out("dir_w");

    // Watchdog: 20 cycles of motor then latched fault
    sense(200, 100, 0, 100);
    for (int i = 0; i < 20; i++) cyc(E_N, "wd_run");
    cyc(E_FLT, "wd_fault");
    sense(100, 100, 100, 100);
    cyc(E_FLT, "wd_hold0");
    cyc(E_FLT, "wd_hold1");
    bus.clr_fault = 1'b1;
    cyc(E_IDLE, "wd_clr");
    bus.clr_fault = 1'b0;
    cyc(E_IDLE, "wd_idle");

    // Enable drop mid-move; en low does not shorten the dwell
    sense(200, 100, 0, 100);
    cyc(E_N, "en_start");
    cyc(E_N, "en_run");
    bus.en = 1'b0;
    cyc(E_SET, "en_drop");
    settle_out("en_drop");
    cyc(E_IDLE, "en_low_idle");
    bus.en = 1'b1;
    cyc(E_N, "en_restart");

    // Reset mid-RUN, then reset in FAULT
    rst = 1'b1;
    cyc(E_IDLE, "rst_run");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) cyc(E_N, "rst_run2");
    cyc(E_FLT, "rst_fault_in");
    rst = 1'b1;
    cyc(E_IDLE, "rst_fault");
    rst = 1'b0;
    sense(100, 100, 100, 100);
    cyc(E_IDLE, "rst_idle");

    // Stop arriving on the final watchdog cycle wins over fault
    sense(200, 100, 0, 100);
    for (int i = 0; i < 20; i++) cyc(E_N, "sim_run");
    sense(100, 100, 100, 100);
    cyc(E_SET, "sim_stop");
    settle_out("sim");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end
endmodule
